// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter unit for the IF stage.
// Picks the next fetch address from the exception vector, a branch/jump redirect,
// a redirect buffered while IF was stalled, or the sequential increment.
// It also produces a one-cycle flush pulse for IF/ID and flags a misaligned PC.
module pc_ctrl #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = 32'h0000_3000,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = 32'h0000_4180,
    parameter int                 INST_BYTES   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             nWrite,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             redirect_pending,
    output logic             flush,
    output logic             misalign
);

    localparam int             ALIGN_BITS = $clog2(INST_BYTES);
    localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(INST_BYTES);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             valid_q, valid_d;
    logic             pending_q, pending_d;
    logic             flush_q, flush_d;

    // Next-state selection in priority order: exception, live redirect, buffered redirect,
    // sequential step, then stall (which may capture a redirect into the one-entry buffer).
    // The first edge after reset only marks the PC valid and ignores all inputs.
    always_comb begin
        pc_d      = pc_q;
        target_d  = target_q;
        pending_d = pending_q;
        flush_d   = 1'b0;
        valid_d   = 1'b1;
        if (!valid_q) begin
            pc_d = pc_q;
        end else if (exc_valid) begin
            pc_d      = EXC_VECTOR;
            pending_d = 1'b0;
            target_d  = '0;
            flush_d   = 1'b1;
        end else if (!nWrite && redirect_valid) begin
            pc_d      = redirect_target;
            pending_d = 1'b0;
            target_d  = '0;
            flush_d   = 1'b1;
        end else if (!nWrite && pending_q) begin
            pc_d      = target_q;
            pending_d = 1'b0;
            target_d  = '0;
            flush_d   = 1'b1;
        end else if (!nWrite) begin
            pc_d = pc_q + PC_STEP;
        end else if (redirect_valid) begin
            target_d  = redirect_target;
            pending_d = 1'b1;
        end
    end

    // State registers; the active-low reset is asynchronous and overrides every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_VECTOR;
            target_q  <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            target_q  <= target_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            flush_q   <= flush_d;
        end
    end

    assign pc               = pc_q;
    assign pc_valid         = valid_q;
    assign redirect_pending = pending_q;
    assign flush            = flush_q;

    // Misalignment is purely informational; with single-byte instructions it cannot occur.
    generate
        if (ALIGN_BITS == 0) begin : gNoAlign
            assign misalign = 1'b0;
        end else begin : gAlign
            assign misalign = |pc_q[ALIGN_BITS-1:0];
        end
    endgenerate

endmodule
